puf_response_stabilizer: RTL and testbench
==========================================

Name: puf_response_stabilizer

Overview:
- Parametrised successor to the combinational PUF-response-to-number converter.
- Collects NUM_SAMPLES back-to-back readings of a RESP_W-bit PUF response and performs a per-bit majority vote.
- Outputs the voted response as the device number, plus a per-bit stability mask and an unstable-bit count.
- Sits between the PUF core and the key/ID logic; the ID path consumes response_number only when done pulses.

Parameters:
- RESP_W, 16: width of the PUF response and of response_number.
- NUM_SAMPLES, 7: readings per evaluation; must be odd and at least 3.
- MAX_UNSTABLE, 2: error is raised when unstable_count exceeds this value.
- CNT_W, $clog2(NUM_SAMPLES+1): width of the per-bit ones counters and the sample counter (derived; not overridden).

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin an evaluation; honoured only in IDLE.
- abort, input, 1: cancel an evaluation in progress.
- resp_valid, input, 1: PUF reading present on resp_data.
- resp_data, input, RESP_W: one PUF reading.
- resp_ready, output, 1: block accepts a reading this cycle.
- busy, output, 1: high in COLLECT and VOTE.
- done, output, 1: one-cycle pulse when result outputs update.
- response_number, output, RESP_W: majority-voted response.
- stable_mask, output, RESP_W: 1 = bit identical across all samples.
- unstable_count, output, $clog2(RESP_W+1): number of zero bits in stable_mask.
- error, output, 1: unstable_count > MAX_UNSTABLE.

Behaviour:
- Reset (asynchronous, any state):
  - state becomes IDLE.
  - All counters, response_number, stable_mask, unstable_count, error, done, busy and resp_ready go to 0.
- States: IDLE, COLLECT, VOTE, DONE.
- IDLE:
  - resp_ready=0, busy=0.
  - start=1 moves to COLLECT on the next edge and clears the per-bit ones counters and the sample counter on that same edge.
- COLLECT:
  - resp_ready=1, busy=1.
  - A handshake is resp_valid && resp_ready. Only handshakes are counted; valid gaps are allowed and are not counted.
  - On each handshake, ones_cnt[i] increments when resp_data[i]=1, and sample_cnt increments.
  - The handshake that brings sample_cnt to NUM_SAMPLES moves the block to VOTE. resp_ready drops in VOTE, so extra readings are never accepted.
- VOTE (one cycle, busy=1, resp_ready=0). The following are registered on the exit edge:
  - response_number[i] = (ones_cnt[i] > NUM_SAMPLES/2).
  - stable_mask[i] = (ones_cnt[i]==0) || (ones_cnt[i]==NUM_SAMPLES).
  - unstable_count = popcount(~stable_mask).
  - error = unstable_count > MAX_UNSTABLE.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - Result outputs hold until the next VOTE or reset.
- Latency: done is high in the second cycle after the final handshake (final handshake edge, then VOTE, then DONE).
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and nothing starts.
- abort in COLLECT or VOTE:
  - Returns to IDLE on the next edge with no done pulse.
  - Result outputs keep their previous values; partial counts are discarded.
- abort in DONE is ignored, so the done pulse still occurs.
- Counter widths cannot overflow: the sample count is capped at NUM_SAMPLES by the state transition.

Decomposition:
- Package puf_pkg holds:
  - the state encoding (IDLE=0, COLLECT=1, VOTE=2, DONE=3);
  - a function computing CNT_W;
  - a popcount function.
- One sub-module, puf_bit_vote_counter, instantiated RESP_W times by generate:
  - contains one ones counter with clear and enable;
  - produces the majority bit and the stable bit.

Test Plan:
- Seven handshakes of 0xA5C3 -> response_number=0xA5C3, stable_mask=0xFFFF, unstable_count=0, error=0, done two cycles after the 7th handshake.
- Samples 0x0001 x4 then 0x0000 x3 -> response_number=0x0001, stable_mask=0xFFFE, unstable_count=1, error=0.
- Samples 0x000F x4 then 0x0000 x3 -> response_number=0x000F, stable_mask=0xFFF0, unstable_count=4, error=1.
- resp_valid toggling every other cycle over 14 cycles with 0x1234 -> exactly 7 samples counted, result 0x1234.
- Extra readings held valid past the 7th -> not accepted (resp_ready=0 in VOTE).
- abort after 3 handshakes, then a fresh start with 7 x 0x00FF:
  - abort -> IDLE, no done, outputs keep the prior result;
  - fresh run -> 0x00FF (no stale counts).
- rst asserted mid-COLLECT -> all outputs 0 immediately, state IDLE, next start behaves normally.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response stabilizer.
//   state_t    : controller state encoding
//   cnt_width  : width needed to hold a count of 0..n
//   popcount   : number of set bits in a vector of up to POP_MAX_W bits
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int POP_MAX_W = 64;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int popcount(input logic [POP_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/puf_bit_vote_counter.sv
// Per-bit ones counter for the stabilizer.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : zero the counter (takes priority over en)
//   en         : a reading is being accepted this cycle
//   bit_in     : this bit of the accepted reading
//   majority   : more than half of the samples were 1
//   stable     : all samples agreed (all 0 or all 1)
module puf_bit_vote_counter #(
    parameter int NUM_SAMPLES = 7,
    parameter int CNT_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic majority,
    output logic stable
);

    logic [CNT_W-1:0] ones_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt <= '0;
        end else if (clr) begin
            ones_cnt <= '0;
        end else if (en && bit_in) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

    assign majority = (ones_cnt > CNT_W'(NUM_SAMPLES / 2));
    assign stable   = (ones_cnt == '0) || (ones_cnt == CNT_W'(NUM_SAMPLES));

endmodule

// File: rtl/puf_response_stabilizer.sv
// Majority-vote stabilizer for a noisy PUF response.
// Collects NUM_SAMPLES accepted readings, votes each bit, and reports the
// voted number together with a stability mask and an unstable-bit count.
//   clk, rst        : clock, asynchronous active-high reset
//   start, abort    : begin an evaluation / cancel one in progress
//   resp_valid/data : PUF reading; accepted when resp_ready is also high
//   resp_ready      : reading accepted this cycle (COLLECT only)
//   busy            : evaluation in progress (COLLECT, VOTE)
//   done            : one-cycle pulse when the result registers update
//   response_number : voted response
//   stable_mask     : 1 where all samples agreed
//   unstable_count  : zero bits in stable_mask
//   error           : unstable_count > MAX_UNSTABLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; counters hold stale data until cleared
// COLLECT | accepting readings until NUM_SAMPLES handshakes are counted
// VOTE    | counters final; result registers load on the exit edge
// DONE    | done pulse for one cycle, then back to IDLE
module puf_response_stabilizer
    import puf_pkg::*;
#(
    parameter int RESP_W       = 16,
    parameter int NUM_SAMPLES  = 7,
    parameter int MAX_UNSTABLE = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        resp_valid,
    input  logic [RESP_W-1:0]           resp_data,
    output logic                        resp_ready,
    output logic                        busy,
    output logic                        done,
    output logic [RESP_W-1:0]           response_number,
    output logic [RESP_W-1:0]           stable_mask,
    output logic [$clog2(RESP_W+1)-1:0] unstable_count,
    output logic                        error
);

    localparam int CNT_W = cnt_width(NUM_SAMPLES);
    localparam int UC_W  = $clog2(RESP_W + 1);

    if ((NUM_SAMPLES < 3) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_samples
        $error("NUM_SAMPLES must be odd and at least 3");
    end
    if (RESP_W > POP_MAX_W) begin : g_bad_width
        $error("RESP_W exceeds popcount width");
    end

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    sample_cnt;
    logic                clr_cnt;
    logic                hs;
    logic                cnt_en;
    logic                vote_load;
    logic [RESP_W-1:0]   maj_bits;
    logic [RESP_W-1:0]   stab_bits;
    logic [POP_MAX_W-1:0] unstab_ext;
    int                  unst_int;

    assign resp_ready = (state == ST_COLLECT);
    assign busy       = (state == ST_COLLECT) || (state == ST_VOTE);
    assign done       = (state == ST_DONE);
    assign hs         = resp_valid && resp_ready;
    // An aborting cycle discards its reading; the counters are cleared on the next start anyway.
    assign cnt_en     = hs && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        vote_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_COLLECT;
                    clr_cnt   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (hs && (sample_cnt == CNT_W'(NUM_SAMPLES - 1))) begin
                    state_nxt = ST_VOTE;
                end
            end
            ST_VOTE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_DONE;
                    vote_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (clr_cnt) begin
            sample_cnt <= '0;
        end else if (cnt_en) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < RESP_W; i++) begin : g_bit
        puf_bit_vote_counter #(
            .NUM_SAMPLES (NUM_SAMPLES),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr_cnt),
            .en       (cnt_en),
            .bit_in   (resp_data[i]),
            .majority (maj_bits[i]),
            .stable   (stab_bits[i])
        );
    end

    always_comb begin
        unstab_ext             = '0;
        unstab_ext[RESP_W-1:0] = ~stab_bits;
        unst_int               = popcount(unstab_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            response_number <= '0;
            stable_mask     <= '0;
            unstable_count  <= '0;
            error           <= 1'b0;
        end else if (vote_load) begin
            response_number <= maj_bits;
            stable_mask     <= stab_bits;
            unstable_count  <= UC_W'(unst_int);
            error           <= (unst_int > MAX_UNSTABLE);
        end
    end

endmodule

// File: tb/tb_puf_response_stabilizer.sv
module tb_puf_response_stabilizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic [15:0] response_number;
    logic [15:0] stable_mask;
    logic [4:0]  unstable_count;
    logic        error;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_num;
    logic [15:0] m_mask;
    int          m_unst;
    logic        m_err;

    puf_response_stabilizer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_ready      (resp_ready),
        .busy            (busy),
        .done            (done),
        .response_number (response_number),
        .stable_mask     (stable_mask),
        .unstable_count  (unstable_count),
        .error           (error)
    );

    always #5 clk = ~clk;

    // Reference: count ones per bit over the accepted samples and apply the voting rules.
    task automatic model(input logic [15:0] s[7]);
        int ones;
        m_num  = '0;
        m_mask = '0;
        m_unst = 0;
        for (int b = 0; b < 16; b++) begin
            ones = 0;
            for (int k = 0; k < 7; k++) ones += int'(s[k][b]);
            m_num[b]  = (ones > 3);
            m_mask[b] = (ones == 0) || (ones == 7);
            if (!m_mask[b]) m_unst++;
        end
        m_err = (m_unst > 2);
    endtask

    // mode 0: valid every cycle (held into VOTE), 1: every other cycle, 2: random gaps
    task automatic run_eval(input logic [15:0] s[7], input int mode, input string name);
        int acc;
        int cyc;
        logic v;
        acc = 0;
        cyc = 0;
        model(s);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; resp_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start got=%b want=1", name, busy);
        end
        while (acc < 7 && cyc < 200) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = ((cyc % 2) == 0);
            else v = 1'($urandom_range(0, 1));
            resp_valid = v;
            resp_data  = v ? s[acc] : 16'($urandom);
            start      = 1'($urandom_range(0, 1));
            checks++;
            if (resp_ready !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s collect_ready got ready=%b done=%b want ready=1 done=0",
                         name, resp_ready, done);
            end
            if (v) acc++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (acc < 7) begin
            failures++;
            $display("FAIL %s collect_timeout got=%0d want=7", name, acc);
        end
        // VOTE: extra readings offered but must not be accepted
        start      = 1'b0;
        resp_valid = (mode == 0);
        resp_data  = 16'($urandom);
        checks++;
        if (resp_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s vote_cycle got ready=%b busy=%b done=%b want 0 1 0",
                     name, resp_ready, busy, done);
        end
        @(negedge clk);
        resp_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_latency got=%b want=1", name, done);
        end
        checks++;
        if (response_number !== m_num || stable_mask !== m_mask ||
            unstable_count !== 5'(m_unst) || error !== m_err) begin
            failures++;
            $display("FAIL %s result got num=%h mask=%h unst=%0d err=%b want num=%h mask=%h unst=%0d err=%b",
                     name, response_number, stable_mask, unstable_count, error,
                     m_num, m_mask, m_unst, m_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; resp_valid = 1'b0; resp_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (response_number !== 16'h0 || stable_mask !== 16'h0 || unstable_count !== 5'd0 ||
            error !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || resp_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got num=%h mask=%h unst=%0d err=%b done=%b busy=%b rdy=%b want all 0",
                     response_number, stable_mask, unstable_count, error, done, busy, resp_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] s[7];
        s = '{default: 16'hA5C3};
        run_eval(s, 0, "all_same");
        checks++;
        if (response_number !== 16'hA5C3 || stable_mask !== 16'hFFFF ||
            unstable_count !== 5'd0 || error !== 1'b0) begin
            failures++;
            $display("FAIL all_same_const got num=%h mask=%h unst=%0d err=%b want a5c3 ffff 0 0",
                     response_number, stable_mask, unstable_count, error);
        end
        s = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        run_eval(s, 0, "one_unstable");
        checks++;
        if (response_number !== 16'h0001 || stable_mask !== 16'hFFFE ||
            unstable_count !== 5'd1 || error !== 1'b0) begin
            failures++;
            $display("FAIL one_unstable_const got num=%h mask=%h unst=%0d err=%b want 0001 fffe 1 0",
                     response_number, stable_mask, unstable_count, error);
        end
        s = '{16'h000F, 16'h000F, 16'h000F, 16'h000F, 16'h0000, 16'h0000, 16'h0000};
        run_eval(s, 0, "four_unstable");
        checks++;
        if (response_number !== 16'h000F || stable_mask !== 16'hFFF0 ||
            unstable_count !== 5'd4 || error !== 1'b1) begin
            failures++;
            $display("FAIL four_unstable_const got num=%h mask=%h unst=%0d err=%b want 000f fff0 4 1",
                     response_number, stable_mask, unstable_count, error);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] s[7];
        s = '{default: 16'h1234};
        run_eval(s, 1, "valid_gaps");
        checks++;
        if (response_number !== 16'h1234) begin
            failures++;
            $display("FAIL valid_gaps_const got=%h want=1234", response_number);
        end
    endtask

    task automatic test_abort();
        logic [15:0] s[7];
        logic [15:0] prev_num;
        logic [15:0] prev_mask;
        s = '{default: 16'h00FF};
        prev_num  = response_number;
        prev_mask = stable_mask;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle got busy=%b want=0", busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp_data = 16'hFF00;
            @(negedge clk);
        end
        abort = 1'b1; resp_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || response_number !== prev_num ||
                stable_mask !== prev_mask) begin
                failures++;
                $display("FAIL abort_hold got busy=%b done=%b num=%h mask=%h want 0 0 %h %h",
                         busy, done, response_number, stable_mask, prev_num, prev_mask);
            end
            @(negedge clk);
        end
        run_eval(s, 0, "after_abort");
        checks++;
        if (response_number !== 16'h00FF || stable_mask !== 16'hFFFF) begin
            failures++;
            $display("FAIL after_abort_const got num=%h mask=%h want 00ff ffff",
                     response_number, stable_mask);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s[7];
        s = '{default: 16'hA5C3};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp_data = 16'h5A5A;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (response_number !== 16'h0 || stable_mask !== 16'h0 || unstable_count !== 5'd0 ||
            error !== 1'b0 || busy !== 1'b0 || resp_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got num=%h mask=%h unst=%0d err=%b busy=%b rdy=%b done=%b want all 0",
                     response_number, stable_mask, unstable_count, error, busy, resp_ready, done);
        end
        resp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_eval(s, 2, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] s[7];
        logic [15:0] base;
        logic [15:0] noise;
        for (int t = 0; t < 25; t++) begin
            base  = 16'($urandom);
            noise = 16'($urandom) & 16'($urandom) & 16'($urandom);
            for (int k = 0; k < 7; k++) s[k] = base ^ (noise & 16'($urandom));
            run_eval(s, t % 3, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
